// File: rtl/mux_stream_n.sv
// N-channel stream multiplexer with fixed-select or round-robin arbitration and a one-word output register.
// Optional accepted-input counter on output grant_cnt when MUX_STREAM_GRANT_CNT_EN is defined.
module mux_stream_n #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
`ifdef MUX_STREAM_GRANT_CNT_EN
    ,
    output logic [15:0]               grant_cnt
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SEL_W-1:0]  r_ptr;
    logic [SEL_W-1:0]  r_chan;
    logic [WIDTH-1:0]  r_data;

    logic              w_load_en;
    logic              w_gvalid;
    logic              w_accept;
    logic [SEL_W-1:0]  w_grant;
    logic [SEL_W-1:0]  w_rr_grant;
    logic              w_rr_found;
    logic [SEL_W:0]    w_sum;
    logic [WIDTH-1:0]  w_gdata;

    // Round-robin search starts just past the last accepted channel and wraps.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_grant = '0;
        w_sum      = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            w_sum = {1'b0, r_ptr} + (SEL_W+1)'(i);
            if (w_sum >= (SEL_W+1)'(CHANNELS))
                w_sum = w_sum - (SEL_W+1)'(CHANNELS);
            if (!w_rr_found && in_valid[w_sum[SEL_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_grant = w_sum[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        if (mode) begin
            w_grant  = w_rr_grant;
            w_gvalid = w_rr_found;
        end else begin
            w_grant  = select;
            w_gvalid = ({1'b0, select} < (SEL_W+1)'(CHANNELS));
        end
    end

    always_comb begin
        in_ready = '0;
        w_gdata  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            in_ready[c] = !rst && w_load_en && w_gvalid && (w_grant == SEL_W'(c));
            if (w_grant == SEL_W'(c))
                w_gdata = in_data[c*WIDTH +: WIDTH];
        end
    end

    assign w_accept = |(in_ready & in_valid);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // FSM: outputs
    always_comb begin
        out_valid = (r_state == ST_FULL);
        w_load_en = (r_state == ST_EMPTY) || out_ready;
        out_data  = r_data;
        out_chan  = r_chan;
    end

    // Output word and arbitration pointer only move on an accepted input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_chan <= '0;
            r_ptr  <= SEL_W'(CHANNELS-1);
        end else if (w_accept) begin
            r_data <= w_gdata;
            r_chan <= w_grant;
            r_ptr  <= w_grant;
        end
    end

`ifdef MUX_STREAM_GRANT_CNT_EN
    logic [15:0] r_gcnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_gcnt <= '0;
        else if (w_accept && (r_gcnt != 16'hFFFF))
            r_gcnt <= r_gcnt + 16'd1;
    end

    assign grant_cnt = r_gcnt;
`endif

endmodule

// File: tb/tb_mux_stream_n.sv
// Directed testbench for mux_stream_n: default 8-channel instance plus a 6-channel instance for out-of-range select.
module tb_mux_stream_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic        mode;
    logic [2:0]  select;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_chan;

    logic [23:0] in_data6;
    logic [5:0]  in_valid6;
    logic [5:0]  in_ready6;
    logic [3:0]  out_data6;
    logic        out_valid6;
    logic [2:0]  out_chan6;

`ifdef MUX_STREAM_GRANT_CNT_EN
    logic [15:0] grant_cnt;
    logic [15:0] grant_cnt6;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_stream_n #(.WIDTH(4), .CHANNELS(8), .SEL_W(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .select    (select),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
`ifdef MUX_STREAM_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    mux_stream_n #(.WIDTH(4), .CHANNELS(6), .SEL_W(3)) u_dut6 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data6),
        .in_valid  (in_valid6),
        .in_ready  (in_ready6),
        .mode      (mode),
        .select    (select),
        .out_data  (out_data6),
        .out_valid (out_valid6),
        .out_ready (out_ready),
        .out_chan  (out_chan6)
`ifdef MUX_STREAM_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt6)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; select = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
        in_data = 32'h76A43210;
        tick(); tick();
        n_tests++;
        if (in_ready !== 8'h00) begin n_fail++; $display("FAIL reset_in_ready: got %h expected 00", in_ready); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++;
        if (out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_tests++;
        if (out_chan !== 3'd0) begin n_fail++; $display("FAIL reset_out_chan: got %0d expected 0", out_chan); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_fixed();
        mode = 1'b0; select = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
        in_data = 32'h76A43210;
        #1;
        n_tests++;
        if (in_ready !== 8'h20) begin n_fail++; $display("FAIL fixed_in_ready: got %h expected 20", in_ready); end
        tick();
        n_tests++;
        if ({out_valid, out_chan, out_data} !== {1'b1, 3'd5, 4'hA}) begin
            n_fail++; $display("FAIL fixed_first_word: got v=%b ch=%0d d=%h expected v=1 ch=5 d=a", out_valid, out_chan, out_data);
        end
        n_tests++;
        if (in_ready !== 8'h20) begin n_fail++; $display("FAIL fixed_full_ready: got %h expected 20", in_ready); end
        in_data = 32'h76B43210;
        tick();
        n_tests++;
        if ({out_valid, out_data} !== {1'b1, 4'hB}) begin
            n_fail++; $display("FAIL fixed_back_to_back: got v=%b d=%h expected v=1 d=b", out_valid, out_data);
        end
        in_valid = 8'h00;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fixed_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ch [6];
        exp_ch = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2, 3'd7};
        in_valid = 8'h00;
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 1'b1; in_valid = 8'b1000_0101; out_ready = 1'b1;
        in_data = 32'hFEDCBA98;
        #1;
        n_tests++;
        if (in_ready !== 8'h01) begin n_fail++; $display("FAIL rr_first_ready: got %h expected 01", in_ready); end
        for (int k = 0; k < 6; k++) begin
            tick();
            n_tests++;
            if ({out_valid, out_chan, out_data} !== {1'b1, exp_ch[k], 4'(8 + exp_ch[k])}) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                         k, out_valid, out_chan, out_data, exp_ch[k], 4'(8 + exp_ch[k]));
            end
        end
        in_valid = 8'h00;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        mode = 1'b0; select = 3'd3; in_valid = 8'hFF; out_ready = 1'b1;
        in_data = 32'h76543210;
        tick();
        out_ready = 1'b0;
        in_data = 32'h76549210;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_ready[%0d]: got %h expected 00", k, in_ready); end
            tick();
            n_tests++;
            if ({out_valid, out_chan, out_data} !== {1'b1, 3'd3, 4'h3}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=3 d=3", k, out_valid, out_chan, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 8'h08) begin n_fail++; $display("FAIL bp_release_ready: got %h expected 08", in_ready); end
        tick();
        n_tests++;
        if ({out_valid, out_data} !== {1'b1, 4'h9}) begin
            n_fail++; $display("FAIL bp_release_word: got v=%b d=%h expected v=1 d=9", out_valid, out_data);
        end
        in_valid = 8'h00;
        tick();
    endtask

    task automatic test_bad_select();
        in_valid6 = 6'h00;
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 1'b0; select = 3'd7; in_valid6 = 6'h3F; in_data6 = 24'h543210; out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready6 !== 6'h00) begin n_fail++; $display("FAIL badsel_ready: got %h expected 00", in_ready6); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (out_valid6 !== 1'b0) begin n_fail++; $display("FAIL badsel_valid[%0d]: got %b expected 0", k, out_valid6); end
        end
        select = 3'd6;
        #1;
        n_tests++;
        if (in_ready6 !== 6'h00) begin n_fail++; $display("FAIL badsel6_ready: got %h expected 00", in_ready6); end
        select = 3'd5;
        #1;
        n_tests++;
        if (in_ready6 !== 6'h20) begin n_fail++; $display("FAIL sel5_ready6: got %h expected 20", in_ready6); end
        tick();
        n_tests++;
        if ({out_valid6, out_chan6, out_data6} !== {1'b1, 3'd5, 4'h5}) begin
            n_fail++; $display("FAIL sel5_word6: got v=%b ch=%0d d=%h expected v=1 ch=5 d=5", out_valid6, out_chan6, out_data6);
        end
        in_valid6 = 6'h00;
        tick();
    endtask

    task automatic test_reset_midflight();
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1; in_data = 32'hFEDCBA98;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_full: got %b expected 1", out_valid); end
        rst = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 8'h00) begin n_fail++; $display("FAIL midrst_ready: got %h expected 00", in_ready); end
        tick();
        n_tests++;
        if ({out_valid, out_data, out_chan} !== {1'b0, 4'h0, 3'd0}) begin
            n_fail++; $display("FAIL midrst_clear: got v=%b d=%h ch=%0d expected v=0 d=0 ch=0", out_valid, out_data, out_chan);
        end
        rst = 1'b0; out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 8'h01) begin n_fail++; $display("FAIL midrst_grant: got %h expected 01", in_ready); end
        tick();
        n_tests++;
        if ({out_valid, out_chan, out_data} !== {1'b1, 3'd0, 4'h8}) begin
            n_fail++; $display("FAIL midrst_word: got v=%b ch=%0d d=%h expected v=1 ch=0 d=8", out_valid, out_chan, out_data);
        end
        n_tests++;
        if (in_ready !== 8'h02) begin n_fail++; $display("FAIL midrst_next_grant: got %h expected 02", in_ready); end
        in_valid = 8'h00;
        tick();
    endtask

`ifdef MUX_STREAM_GRANT_CNT_EN
    task automatic test_grant_cnt();
        in_valid = 8'h00;
        rst = 1'b1; tick(); rst = 1'b0;
        n_tests++;
        if (grant_cnt !== 16'd0) begin n_fail++; $display("FAIL gcnt_reset: got %h expected 0000", grant_cnt); end
        mode = 1'b0; select = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
        tick();
        n_tests++;
        if (grant_cnt !== 16'd1) begin n_fail++; $display("FAIL gcnt_one: got %h expected 0001", grant_cnt); end
        repeat (69999) tick();
        n_tests++;
        if (grant_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL gcnt_sat: got %h expected ffff", grant_cnt); end
        repeat (5) tick();
        n_tests++;
        if (grant_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL gcnt_hold: got %h expected ffff", grant_cnt); end
        in_valid = 8'h00;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; select = '0; out_ready = 1'b0;
        in_data6 = '0; in_valid6 = '0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_bad_select();
        test_reset_midflight();
`ifdef MUX_STREAM_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
